// File: rtl/desynk_pkg.sv
// rtl/desynk_pkg.sv - shared types and glitch polarity helpers for the glitch sequencer
// Contents:
//   seq_state_t               : sequencer FSM states (3-bit encoding)
//   GLITCH_ACTIVE/GLITCH_IDLE : logical glitch levels before the polarity mapping
//   glitch_level()            : maps a logical glitch level onto the physical pin level
package desynk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESETTING = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_DELAY     = 3'd3,
        ST_GLITCH    = 3'd4
    } seq_state_t;

    localparam logic GLITCH_ACTIVE = 1'b1;
    localparam logic GLITCH_IDLE   = 1'b0;

    function automatic logic glitch_level(input bit active_high, input logic level);
        return active_high ? level : ~level;
    endfunction

endpackage

// File: rtl/target_glitch_sequencer_if.sv
// rtl/target_glitch_sequencer_if.sv - command/status bundle between campaign controller and sequencer
// Signals:
//   start, abort                 : attempt control (controller -> sequencer)
//   delay_cycles, width_cycles,
//   boot_timeout                 : attempt parameters, latched by the sequencer at start
//   busy, done, timed_out        : attempt status (sequencer -> controller)
// Modports: master = controller side, slave = sequencer side.
interface target_glitch_sequencer_if;
    logic        start;
    logic        abort;
    logic [31:0] delay_cycles;
    logic [15:0] width_cycles;
    logic [31:0] boot_timeout;
    logic        busy;
    logic        done;
    logic        timed_out;

    modport master (
        output start, abort, delay_cycles, width_cycles, boot_timeout,
        input  busy, done, timed_out
    );

    modport slave (
        input  start, abort, delay_cycles, width_cycles, boot_timeout,
        output busy, done, timed_out
    );
endinterface

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - multi-flop synchronizer with rising-edge detect for async inputs
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset, clears all flops
//   d    : asynchronous input
//   rise : high for one cycle after a synchronized 0->1 transition of d
module sync_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/target_glitch_sequencer.sv
// rtl/target_glitch_sequencer.sv - per-attempt sequencer: reset target, wait for ready, delay, glitch
// Ports:
//   clk, rst      : system clock, synchronous active-high reset
//   ctl (slave)   : start/abort, latched delay/width/timeout, busy/done/timed_out status
//   target_trig   : asynchronous target ready GPIO, rising edge = ready
//   reset_trigger : one-cycle pulse into the downstream reset module
//   glitch_out    : glitch drive, active level set by GLITCH_ACTIVE_HIGH
module target_glitch_sequencer
    import desynk_pkg::*;
#(
    parameter int unsigned RESET_CYCLES       = 480000,
    parameter int          SYNC_STAGES        = 2,
    parameter bit          GLITCH_ACTIVE_HIGH = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst,
    target_glitch_sequencer_if.slave        ctl,
    input  logic                            target_trig,
    output logic                            reset_trigger,
    output logic                            glitch_out
);

    localparam logic        G_ON        = glitch_level(GLITCH_ACTIVE_HIGH, GLITCH_ACTIVE);
    localparam logic        G_OFF       = glitch_level(GLITCH_ACTIVE_HIGH, GLITCH_IDLE);
    localparam logic [31:0] RESET_LIMIT = RESET_CYCLES;

    seq_state_t  state;
    logic [31:0] counter;
    logic [31:0] delay_q;
    logic [15:0] width_q;
    logic [31:0] timeout_q;
    logic        trig_rise;

    sync_edge_detect #(
        .STAGES (SYNC_STAGES)
    ) u_trig_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (target_trig),
        .rise (trig_rise)
    );

    // counter semantics per state:
    //   RESETTING       : cycles spent in reset, starting at 1
    //   WAIT_TRIG       : cycles elapsed since entry, starting at 0
    //   DELAY / GLITCH  : current cycle index of the phase, starting at 1
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            counter       <= '0;
            delay_q       <= '0;
            width_q       <= '0;
            timeout_q     <= '0;
            reset_trigger <= 1'b0;
            glitch_out    <= G_OFF;
            ctl.busy      <= 1'b0;
            ctl.done      <= 1'b0;
            ctl.timed_out <= 1'b0;
        end else begin
            reset_trigger <= 1'b0;
            ctl.done      <= 1'b0;

            if (ctl.abort) begin
                // silent return: no done pulse, last status kept
                state      <= ST_IDLE;
                counter    <= '0;
                glitch_out <= G_OFF;
                ctl.busy   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (ctl.start) begin
                            delay_q       <= ctl.delay_cycles;
                            width_q       <= (ctl.width_cycles == 16'd0) ? 16'd1 : ctl.width_cycles;
                            timeout_q     <= ctl.boot_timeout;
                            reset_trigger <= 1'b1;
                            ctl.timed_out <= 1'b0;
                            ctl.busy      <= 1'b1;
                            counter       <= 32'd1;
                            state         <= ST_RESETTING;
                        end
                    end

                    ST_RESETTING: begin
                        // target is held in reset; its GPIO edges are meaningless here
                        if (counter >= RESET_LIMIT) begin
                            counter <= '0;
                            state   <= ST_WAIT_TRIG;
                        end else begin
                            counter <= counter + 32'd1;
                        end
                    end

                    ST_WAIT_TRIG: begin
                        if (trig_rise) begin
                            counter <= 32'd1;
                            if (delay_q == 32'd0) begin
                                glitch_out <= G_ON;
                                state      <= ST_GLITCH;
                            end else begin
                                state <= ST_DELAY;
                            end
                        end else if ((timeout_q != 32'd0) && (counter >= timeout_q)) begin
                            ctl.timed_out <= 1'b1;
                            ctl.done      <= 1'b1;
                            ctl.busy      <= 1'b0;
                            counter       <= '0;
                            state         <= ST_IDLE;
                        end else begin
                            counter <= counter + 32'd1;
                        end
                    end

                    ST_DELAY: begin
                        if (counter >= delay_q) begin
                            glitch_out <= G_ON;
                            counter    <= 32'd1;
                            state      <= ST_GLITCH;
                        end else begin
                            counter <= counter + 32'd1;
                        end
                    end

                    ST_GLITCH: begin
                        if (counter >= {16'd0, width_q}) begin
                            glitch_out <= G_OFF;
                            ctl.done   <= 1'b1;
                            ctl.busy   <= 1'b0;
                            counter    <= '0;
                            state      <= ST_IDLE;
                        end else begin
                            counter <= counter + 32'd1;
                        end
                    end

                    default: begin
                        glitch_out <= G_OFF;
                        ctl.busy   <= 1'b0;
                        counter    <= '0;
                        state      <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_target_glitch_sequencer.sv
// tb/tb_target_glitch_sequencer.sv - self-checking bench for target_glitch_sequencer
module tb_target_glitch_sequencer;

    localparam int RC = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic target_trig = 1'b0;
    logic reset_trigger;
    logic glitch_out;

    target_glitch_sequencer_if ctl();

    target_glitch_sequencer #(
        .RESET_CYCLES       (RC),
        .SYNC_STAGES        (2),
        .GLITCH_ACTIVE_HIGH (1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ctl           (ctl),
        .target_trig   (target_trig),
        .reset_trigger (reset_trigger),
        .glitch_out    (glitch_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct {
        int rt;
        int g_first;
        int g_len;
        int done_c;
        bit to;
    } exp_t;

    // expected values are relative to W, the first WAIT_TRIG cycle
    typedef struct {
        int d;
        int w;
        int t;
        int k;
        int first;
        int len;
        int done_rel;
        bit to;
    } vec_t;

    exp_t sb[$];
    vec_t vt[8];

    int g_cnt = 0, g_first = 0, g_last = 0, rt_cnt = 0, rt_cyc = 0;

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task clear_trk();
        g_cnt = 0; g_first = 0; g_last = 0; rt_cnt = 0; rt_cyc = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    always @(negedge clk) begin : mon
        int n;
        exp_t e;
        if (!rst) begin
            if (glitch_out) begin
                if (g_cnt == 0) g_first = cyc;
                g_last = cyc;
                g_cnt++;
            end
            if (reset_trigger) begin
                rt_cnt++;
                rt_cyc = cyc;
            end
            if (ctl.done) begin
                n = sb.size();
                chk("attempt_pending_at_done", int'(n > 0), 1);
                if (n > 0) begin
                    e = sb.pop_front();
                    chk("done_cycle", cyc, e.done_c);
                    chk("timed_out", int'(ctl.timed_out), int'(e.to));
                    chk("busy_at_done", int'(ctl.busy), 0);
                    chk("reset_trigger_pulses", rt_cnt, 1);
                    chk("reset_trigger_cycle", rt_cyc, e.rt);
                    chk("glitch_cycles", g_cnt, e.g_len);
                    if (e.g_len > 0) begin
                        chk("glitch_first", g_first, e.g_first);
                        chk("glitch_last", g_last, e.g_first + e.g_len - 1);
                    end
                end
                clear_trk();
            end
        end
    end

    task automatic start_attempt(input int d, input int w, input int t,
                                 input int first_rel, input int len, input int done_rel,
                                 input bit to, output int wc);
        exp_t e;
        int s;
        s = cyc;
        ctl.delay_cycles = d;
        ctl.width_cycles = w[15:0];
        ctl.boot_timeout = t;
        ctl.start = 1'b1;
        wc = s + RC + 1;
        e.rt = s + 1;
        e.g_first = wc + first_rel;
        e.g_len = len;
        e.done_c = wc + done_rel;
        e.to = to;
        sb.push_back(e);
        step();
        ctl.start = 1'b0;
        chk("busy_after_start", int'(ctl.busy), 1);
    endtask

    task automatic wait_done();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (ctl.done) begin
                got = 1'b1;
                break;
            end
        end
        chk("done_within_bound", int'(got), 1);
    endtask

    task automatic run_vec(input vec_t v);
        int wc;
        target_trig = 1'b0;
        start_attempt(v.d, v.w, v.t, v.first, v.len, v.done_rel, v.to, wc);
        if (v.k >= 0) begin
            wait_until(wc + v.k);
            target_trig = 1'b1;
        end
        wait_done();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=stalled required=finish");
        $fatal(1);
    end

    initial begin
        int wc;
        int s;
        ctl.start = 1'b0;
        ctl.abort = 1'b0;
        ctl.delay_cycles = '0;
        ctl.width_cycles = '0;
        ctl.boot_timeout = '0;

        //         d  w   t   k  first len done to
        vt[0] = '{5, 3,  0,  4, 12, 3, 15, 1'b0};
        vt[1] = '{0, 0,  0,  2,  5, 1,  6, 1'b0};
        vt[2] = '{0, 4, 20, -1,  0, 0, 21, 1'b1};
        vt[3] = '{1, 2, 50,  3,  7, 2,  9, 1'b0};
        vt[4] = '{3, 1,  0,  0,  6, 1,  7, 1'b0};
        vt[5] = '{2, 2,  6,  4,  9, 2, 11, 1'b0};
        vt[6] = '{2, 2,  6,  5,  0, 0,  7, 1'b1};
        vt[7] = '{0, 1,  1, -1,  0, 0,  2, 1'b1};

        repeat (3) step();
        chk("rst_reset_trigger", int'(reset_trigger), 0);
        chk("rst_glitch_out", int'(glitch_out), 0);
        chk("rst_busy", int'(ctl.busy), 0);
        chk("rst_done", int'(ctl.done), 0);
        chk("rst_timed_out", int'(ctl.timed_out), 0);
        rst = 1'b0;
        step();

        // vectors run back to back: each start lands in the done cycle of the previous one
        for (int i = 0; i < 8; i++) run_vec(vt[i]);

        // edges during RESETTING are ignored; trig stays high so no edge in WAIT_TRIG
        step();
        step();
        start_attempt(0, 1, 30, 0, 0, 31, 1'b1, wc);
        s = wc - RC - 1;
        wait_until(s + 3); target_trig = 1'b1;
        wait_until(s + 5); target_trig = 1'b0;
        wait_until(s + 6); target_trig = 1'b1;
        wait_done();

        // fresh edge inside WAIT_TRIG after a low period does fire
        start_attempt(2, 2, 0, 13, 2, 15, 1'b0, wc);
        wait_until(wc + 5); target_trig = 1'b0;
        wait_until(wc + 8); target_trig = 1'b1;
        wait_done();

        // abort in the second GLITCH cycle, then immediate restart
        target_trig = 1'b0;
        repeat (4) step();
        s = cyc;
        ctl.delay_cycles = 1;
        ctl.width_cycles = 10;
        ctl.boot_timeout = 0;
        ctl.start = 1'b1;
        step();
        ctl.start = 1'b0;
        wc = s + RC + 1;
        wait_until(wc + 1); target_trig = 1'b1;
        wait_until(wc + 6); ctl.abort = 1'b1;
        step();
        ctl.abort = 1'b0;
        chk("abort_glitch_off", int'(glitch_out), 0);
        chk("abort_busy", int'(ctl.busy), 0);
        chk("abort_no_done", int'(ctl.done), 0);
        chk("abort_reset_trigger", int'(reset_trigger), 0);
        chk("abort_glitch_cycles", g_cnt, 2);
        chk("abort_glitch_first", g_first, wc + 5);
        clear_trk();
        target_trig = 1'b0;
        start_attempt(0, 1, 5, 0, 0, 6, 1'b1, wc);
        wait_done();

        // start while busy is ignored (single reset_trigger pulse checked at done)
        start_attempt(0, 2, 0, 6, 2, 8, 1'b0, wc);
        s = wc - RC - 1;
        wait_until(s + 4); ctl.start = 1'b1; step(); ctl.start = 1'b0;
        wait_until(wc + 1); ctl.start = 1'b1; step(); ctl.start = 1'b0;
        wait_until(wc + 3); target_trig = 1'b1;
        wait_until(wc + 6); ctl.start = 1'b1; step(); ctl.start = 1'b0;
        wait_done();

        // start together with abort in IDLE is dropped
        target_trig = 1'b0;
        step();
        ctl.start = 1'b1;
        ctl.abort = 1'b1;
        step();
        ctl.start = 1'b0;
        ctl.abort = 1'b0;
        chk("start_abort_busy", int'(ctl.busy), 0);
        chk("start_abort_reset_trigger", int'(reset_trigger), 0);
        step();
        step();
        chk("start_abort_busy_later", int'(ctl.busy), 0);
        chk("start_abort_rt_count", rt_cnt, 0);

        // reset in the middle of a glitch forces glitch_out inactive
        repeat (2) step();
        s = cyc;
        ctl.delay_cycles = 0;
        ctl.width_cycles = 10;
        ctl.boot_timeout = 0;
        ctl.start = 1'b1;
        step();
        ctl.start = 1'b0;
        wc = s + RC + 1;
        wait_until(wc + 1); target_trig = 1'b1;
        wait_until(wc + 5);
        chk("pre_rst_glitch_on", int'(glitch_out), 1);
        rst = 1'b1;
        step();
        chk("mid_rst_glitch_off", int'(glitch_out), 0);
        chk("mid_rst_busy", int'(ctl.busy), 0);
        chk("mid_rst_done", int'(ctl.done), 0);
        chk("mid_rst_reset_trigger", int'(reset_trigger), 0);
        rst = 1'b0;
        target_trig = 1'b0;
        step();
        clear_trk();
        step();
        chk("scoreboard_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
